axi4_stream_pkt_shift: RTL
==========================

AXI4_STREAM_PKT_SHIFT -- requirements
Module: axi4_stream_pkt_shift

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning tdata width in bits (multiple of 8, >= 16).
REQ-002 SHALL have parameters ID_WIDTH, DEST_WIDTH and USER_WIDTH, each default 1, meaning sideband widths.
REQ-003 SHALL have parameter PAD_BYTE, default 8'h00, meaning the data value of inserted bytes.
REQ-004 SHALL have derived parameters DATA_WIDTH_B = DATA_WIDTH/8 and DATA_WIDTH_B_W = $clog2(DATA_WIDTH_B).
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_n_i, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port shift_i, input, DATA_WIDTH_B_W bits: byte shift amount, range 0..DATA_WIDTH_B-1.
REQ-008 SHALL have port mode_i, input, 1 bit: 0 = insert shift_i pad bytes at packet head, 1 = strip shift_i leading bytes.
REQ-009 SHALL have port pkt_i, axi4_stream_if slave: input stream.
REQ-010 SHALL have port pkt_o, axi4_stream_if master: output stream.
REQ-011 SHALL have port drop_o, output, 1 bit: one-cycle pulse when a packet is entirely stripped.

Function
REQ-012 Lane order SHALL be little-endian: byte n of a packet is in tdata[8n+7:8n] of the lowest-numbered beat carrying it.
REQ-013 Input tkeep SHALL be contiguous from lane 0; only the tlast beat may be partial; a byte is valid if its tkeep or tstrb bit is set.
REQ-014 shift_i, mode_i, tid, tdest and tuser SHALL be sampled on acceptance of a packet's first beat and held for the whole packet; mid-packet changes SHALL be ignored.
REQ-015 FSM SHALL have states IDLE (awaiting first beat), BODY (packet in progress) and FLUSH (emitting residual tail beat).
REQ-016 A carry register SHALL hold up to DATA_WIDTH_B-1 residual bytes, together with their tstrb bits.
REQ-017 Insert mode: first output beat SHALL carry shift pad bytes in lanes 0..s-1 (tkeep=1, tstrb=0, data=PAD_BYTE), followed by input bytes 0..B-1-s.
REQ-018 Strip mode: the first s packet bytes SHALL be discarded; no output beat SHALL be emitted until DATA_WIDTH_B bytes or the packet tail have accumulated.
REQ-019 Every non-last output beat SHALL have tkeep all-ones; the tlast beat SHALL have contiguous tkeep covering exactly the remaining bytes.
REQ-020 If the remaining bytes exceed one beat when input tlast is accepted, the FSM SHALL enter FLUSH; pkt_i.tready SHALL be 0 in FLUSH.
REQ-021 The FSM SHALL return from FLUSH to IDLE on acceptance of the tail beat.
REQ-022 If the strip amount is >= the packet length, the module SHALL emit no beat, SHALL pulse drop_o for one cycle, and SHALL return to IDLE.
REQ-023 shift 0 in either mode SHALL pass data through unchanged with 1-cycle latency.
REQ-024 Output SHALL be registered; latency from input accept to the first output beat valid SHALL be 1 cycle, except in strip mode when more input is required.
REQ-025 pkt_i.tready SHALL equal (!pkt_o.tvalid || pkt_o.tready) && state != FLUSH.
REQ-026 Sustained throughput SHALL be one beat per cycle, apart from the FLUSH cycle.
REQ-027 pkt_o.tvalid and all pkt_o payload fields SHALL remain stable while tvalid && !tready.
REQ-028 tid, tdest and tuser on every output beat SHALL equal the values captured from the packet's first input beat.
REQ-029 Back-to-back packets SHALL be accepted with no idle cycle when no FLUSH is needed.
REQ-030 When a tlast beat and the next packet's first beat are adjacent, the carry SHALL never mix bytes of different packets.

Reset
REQ-031 While rst_n_i=0 at a clk_i edge: state <= IDLE, carry cleared, pkt_o.tvalid <= 0, pkt_o.tlast <= 0, tdata/tkeep/tstrb/tid/tdest/tuser <= 0, drop_o <= 0.
REQ-032 While in reset, pkt_i.tready SHALL be 0.
REQ-033 A partial packet in flight at reset SHALL be discarded; the first beat accepted after reset SHALL be treated as a packet start.

Verification (DATA_WIDTH=32, bytes listed lane0 first)
REQ-034 Insert, s=1, packet 01..08 (2 full beats): out {PAD,01,02,03} keep 1111 strb 1110; {04..07}; {08} keep 0001 tlast; tready low for exactly 1 cycle.
REQ-035 Strip, s=2, packet 01..06 (beat1 keep 0011 tlast): single out beat {03,04,05,06}, keep 1111, tlast=1.
REQ-036 Strip, s=3, packet 2 bytes (keep 0011, tlast): no pkt_o.tvalid, drop_o=1 for 1 cycle, next packet correct.
REQ-037 Random s, mode, lengths 1..64 bytes, 30% random pkt_o.tready low, 1000 packets: byte-exact match to model, stable payload under stall, sidebands per packet.
REQ-038 rst_n_i low 1 cycle mid-BODY: pkt_o.tvalid=0 next cycle, no residual bytes leak into the next packet.
REQ-039 s=0, both modes, back-to-back packets: output equals input delayed 1 cycle, no bubbles.

Source files
------------

// File: rtl/axi4_stream_pkt_shift_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_stream_if
//  Purpose  : AXI4-Stream bundle (tvalid/tready handshake, byte-lane tdata
//             with tkeep/tstrb qualifiers, tlast and tid/tdest/tuser sideband).
//  Modports : master - drives payload and tvalid, samples tready
//             slave  - samples payload and tvalid, drives tready
//  Revision : 1.0 - initial release
// ============================================================================
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    output tready
  );
endinterface
`default_nettype wire

// File: rtl/axi4_stream_pkt_shift.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_stream_pkt_shift
//  Purpose  : Per-packet byte realignment of an AXI4-Stream. At the head of
//             each packet either inserts shift_i pad bytes (mode_i=0) or
//             strips shift_i leading bytes (mode_i=1), then repacks the rest
//             of the packet into full beats with a contiguous tail beat.
//  Ports    : clk_i    - clock
//             rst_n_i  - synchronous active-low reset
//             shift_i  - byte shift amount, sampled with the first beat
//             mode_i   - 0 insert pad bytes, 1 strip leading bytes
//             pkt_i    - AXI4-Stream slave (input packets)
//             pkt_o    - AXI4-Stream master (registered output packets)
//             drop_o   - one-cycle pulse when a packet is stripped entirely
//  Revision : 1.0 - initial release
// ============================================================================
module axi4_stream_pkt_shift #(
  parameter int         DATA_WIDTH     = 32,
  parameter int         ID_WIDTH       = 1,
  parameter int         DEST_WIDTH     = 1,
  parameter int         USER_WIDTH     = 1,
  parameter logic [7:0] PAD_BYTE       = 8'h00,
  parameter int         DATA_WIDTH_B   = DATA_WIDTH / 8,
  parameter int         DATA_WIDTH_B_W = $clog2(DATA_WIDTH_B)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [DATA_WIDTH_B_W-1:0] shift_i,
  input  logic                      mode_i,
  axi4_stream_if.slave              pkt_i,
  axi4_stream_if.master             pkt_o,
  output logic                      drop_o
);

  // Byte counts run up to 2*B-1 (carry of B-1 plus a full input beat).
  localparam int CNT_W   = DATA_WIDTH_B_W + 1;
  localparam int CARRY_W = DATA_WIDTH - 8;
  localparam int CAT_W   = 2 * DATA_WIDTH - 8;
  localparam int CAT_B   = 2 * DATA_WIDTH_B - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BODY  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Residual bytes not yet emitted, packed from lane 0 upward.
  logic [CARRY_W-1:0]      r_carry_data;
  logic [DATA_WIDTH_B-2:0] r_carry_strb;
  logic [CNT_W-1:0]        r_carry_cnt;

  logic [ID_WIDTH-1:0]     r_id;
  logic [DEST_WIDTH-1:0]   r_dest;
  logic [USER_WIDTH-1:0]   r_user;

  logic                    r_tvalid;
  logic                    r_tlast;
  logic [DATA_WIDTH-1:0]   r_tdata;
  logic [DATA_WIDTH_B-1:0] r_tkeep;
  logic [DATA_WIDTH_B-1:0] r_tstrb;
  logic [ID_WIDTH-1:0]     r_tid;
  logic [DEST_WIDTH-1:0]   r_tdest;
  logic [USER_WIDTH-1:0]   r_tuser;
  logic                    r_drop;

  logic                    w_out_free;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_first;
  logic [DATA_WIDTH_B-1:0] w_in_vld;
  logic [DATA_WIDTH-1:0]   w_in_data;
  logic [DATA_WIDTH_B-1:0] w_in_strb;
  logic [CNT_W-1:0]        w_in_cnt;
  logic [CAT_W-1:0]        w_in_ext;
  logic [CAT_B-1:0]        w_strb_ext;
  logic [CAT_W-1:0]        w_pad_vec;
  logic [CAT_W-1:0]        w_cat_data;
  logic [CAT_B-1:0]        w_cat_strb;
  logic [CNT_W-1:0]        w_cat_cnt;
  logic                    w_has_full;
  logic [ID_WIDTH-1:0]     w_id;
  logic [DEST_WIDTH-1:0]   w_dest;
  logic [USER_WIDTH-1:0]   w_user;

  function automatic logic [DATA_WIDTH_B-1:0] keep_mask(input logic [CNT_W-1:0] n);
    logic [DATA_WIDTH_B-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_WIDTH_B; i++) begin
      m[i] = (CNT_W'(i) < n);
    end
    return m;
  endfunction

  // A new input beat can only be taken when the output register is free to
  // absorb whatever it produces; FLUSH owns the output register.
  assign w_out_free = !r_tvalid || pkt_o.tready;
  assign w_in_ready = rst_n_i && w_out_free && (r_state != FLUSH);
  assign w_accept   = pkt_i.tvalid && w_in_ready;
  assign w_first    = (r_state == IDLE);

  // Sidebands of the first beat go straight to the output; later beats reuse
  // the captured copy so mid-packet changes are ignored.
  assign w_id   = w_first ? pkt_i.tid   : r_id;
  assign w_dest = w_first ? pkt_i.tdest : r_dest;
  assign w_user = w_first ? pkt_i.tuser : r_user;

  // Input beat cleanup: invalid lanes are zeroed so that byte vectors can be
  // merged with a plain OR.
  always_comb begin
    w_in_vld  = pkt_i.tkeep | pkt_i.tstrb;
    w_in_strb = pkt_i.tstrb;
    w_in_cnt  = '0;
    w_in_data = '0;
    for (int i = 0; i < DATA_WIDTH_B; i++) begin
      if (w_in_vld[i]) begin
        w_in_cnt              = w_in_cnt + CNT_W'(1);
        w_in_data[8*i +: 8]   = pkt_i.tdata[8*i +: 8];
      end
    end
  end

  // Build the combined byte stream "carry then this beat" (or, for a first
  // beat, the head-modified beat) and count its valid bytes.
  always_comb begin
    w_in_ext   = {{(DATA_WIDTH-8){1'b0}}, w_in_data};
    w_strb_ext = {{(DATA_WIDTH_B-1){1'b0}}, w_in_strb};
    w_pad_vec  = '0;
    for (int i = 0; i < DATA_WIDTH_B; i++) begin
      if (CNT_W'(i) < CNT_W'(shift_i)) begin
        w_pad_vec[8*i +: 8] = PAD_BYTE;
      end
    end
    if (w_first && !mode_i) begin
      w_cat_data = (w_in_ext << {shift_i, 3'b000}) | w_pad_vec;
      w_cat_strb = w_strb_ext << shift_i;
      w_cat_cnt  = CNT_W'(shift_i) + w_in_cnt;
    end else if (w_first) begin
      w_cat_data = w_in_ext >> {shift_i, 3'b000};
      w_cat_strb = w_strb_ext >> shift_i;
      w_cat_cnt  = (w_in_cnt > CNT_W'(shift_i)) ? (w_in_cnt - CNT_W'(shift_i)) : '0;
    end else begin
      w_cat_data = (w_in_ext << {r_carry_cnt, 3'b000}) | {{DATA_WIDTH{1'b0}}, r_carry_data};
      w_cat_strb = (w_strb_ext << r_carry_cnt) | {{DATA_WIDTH_B{1'b0}}, r_carry_strb};
      w_cat_cnt  = r_carry_cnt + w_in_cnt;
    end
    w_has_full = (w_cat_cnt >= CNT_W'(DATA_WIDTH_B));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, BODY: begin
        if (w_accept) begin
          if (!pkt_i.tlast) begin
            w_state_nxt = BODY;
          end else if (w_cat_cnt > CNT_W'(DATA_WIDTH_B)) begin
            w_state_nxt = FLUSH;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      FLUSH: begin
        if (w_out_free) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_carry_data <= '0;
      r_carry_strb <= '0;
      r_carry_cnt  <= '0;
      r_id         <= '0;
      r_dest       <= '0;
      r_user       <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_tdata      <= '0;
      r_tkeep      <= '0;
      r_tstrb      <= '0;
      r_tid        <= '0;
      r_tdest      <= '0;
      r_tuser      <= '0;
      r_drop       <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      if (w_out_free) begin
        r_tvalid <= 1'b0;
      end
      if (w_accept) begin
        if (w_first) begin
          r_id   <= pkt_i.tid;
          r_dest <= pkt_i.tdest;
          r_user <= pkt_i.tuser;
        end
        if (w_has_full) begin
          // A full beat is available; anything above it becomes the carry.
          r_tvalid     <= 1'b1;
          r_tlast      <= pkt_i.tlast && (w_cat_cnt == CNT_W'(DATA_WIDTH_B));
          r_tdata      <= w_cat_data[DATA_WIDTH-1:0];
          r_tkeep      <= '1;
          r_tstrb      <= w_cat_strb[DATA_WIDTH_B-1:0];
          r_tid        <= w_id;
          r_tdest      <= w_dest;
          r_tuser      <= w_user;
          r_carry_data <= w_cat_data[DATA_WIDTH +: CARRY_W];
          r_carry_strb <= w_cat_strb[DATA_WIDTH_B +: (DATA_WIDTH_B-1)];
          r_carry_cnt  <= w_cat_cnt - CNT_W'(DATA_WIDTH_B);
        end else if (pkt_i.tlast) begin
          // Short tail: emit it, or report a fully stripped packet.
          if (w_cat_cnt == '0) begin
            r_drop <= 1'b1;
          end else begin
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b1;
            r_tdata  <= w_cat_data[DATA_WIDTH-1:0];
            r_tkeep  <= keep_mask(w_cat_cnt);
            r_tstrb  <= w_cat_strb[DATA_WIDTH_B-1:0];
            r_tid    <= w_id;
            r_tdest  <= w_dest;
            r_tuser  <= w_user;
          end
          r_carry_data <= '0;
          r_carry_strb <= '0;
          r_carry_cnt  <= '0;
        end else begin
          // Not enough bytes for a beat yet; fewer than B bytes by definition.
          r_carry_data <= w_cat_data[CARRY_W-1:0];
          r_carry_strb <= w_cat_strb[DATA_WIDTH_B-2:0];
          r_carry_cnt  <= w_cat_cnt;
        end
      end else if ((r_state == FLUSH) && w_out_free) begin
        r_tvalid     <= 1'b1;
        r_tlast      <= 1'b1;
        r_tdata      <= {8'h00, r_carry_data};
        r_tkeep      <= keep_mask(r_carry_cnt);
        r_tstrb      <= {1'b0, r_carry_strb};
        r_tid        <= r_id;
        r_tdest      <= r_dest;
        r_tuser      <= r_user;
        r_carry_data <= '0;
        r_carry_strb <= '0;
        r_carry_cnt  <= '0;
      end
    end
  end

  assign pkt_i.tready = w_in_ready;
  assign pkt_o.tvalid = r_tvalid;
  assign pkt_o.tlast  = r_tlast;
  assign pkt_o.tdata  = r_tdata;
  assign pkt_o.tkeep  = r_tkeep;
  assign pkt_o.tstrb  = r_tstrb;
  assign pkt_o.tid    = r_tid;
  assign pkt_o.tdest  = r_tdest;
  assign pkt_o.tuser  = r_tuser;
  assign drop_o       = r_drop;

endmodule
`default_nettype wire
